// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_tx
//  Description : Drains an 8-bit synchronous FIFO one byte at a time and
//                transmits each byte as an 8N1 serial frame. The frame is one
//                start bit, eight data bits sent LSB first, and one stop bit.
//                All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_pop,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_pop   = 3'd1;
    localparam logic [2:0] c_st_load  = 3'd2;
    localparam logic [2:0] c_st_start = 3'd3;
    localparam logic [2:0] c_st_data  = 3'd4;
    localparam logic [2:0] c_st_stop  = 3'd5;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic             r_pop;
    logic             r_busy;
    logic             r_done;

    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_clk_cnt_nxt;
    logic [2:0]       w_bit_cnt_nxt;
    logic [7:0]       w_shift_nxt;
    logic             w_tx_nxt;
    logic             w_pop_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_bit_end;
    logic             w_can_start;

    // Next-state, counter and output decode. Outputs are derived from the
    // next state so that the registered versions line up with the state.
    always_comb begin
        w_state_nxt   = r_state;
        w_clk_cnt_nxt = r_clk_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_bit_end     = (r_clk_cnt == c_cnt_last);
        w_can_start   = enable && !fifo_empty;

        case (r_state)
            c_st_idle: begin
                if (w_can_start) begin
                    w_state_nxt = c_st_pop;
                end
            end
            c_st_pop: begin
                w_state_nxt = c_st_load;
            end
            c_st_load: begin
                // The FIFO presents the popped byte in this cycle.
                w_shift_nxt   = fifo_data;
                w_clk_cnt_nxt = '0;
                w_state_nxt   = c_st_start;
            end
            c_st_start: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    w_bit_cnt_nxt = 3'd0;
                    w_state_nxt   = c_st_data;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + c_cnt_one;
                end
            end
            c_st_data: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = c_st_stop;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + c_cnt_one;
                end
            end
            c_st_stop: begin
                if (w_bit_end) begin
                    // Chain straight into the next byte when one is waiting.
                    w_clk_cnt_nxt = '0;
                    w_state_nxt   = w_can_start ? c_st_pop : c_st_idle;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + c_cnt_one;
                end
            end
            default: begin
                w_state_nxt   = c_st_idle;
                w_clk_cnt_nxt = '0;
            end
        endcase

        w_tx_nxt = 1'b1;
        if (w_state_nxt == c_st_start) begin
            w_tx_nxt = 1'b0;
        end else if (w_state_nxt == c_st_data) begin
            w_tx_nxt = w_shift_nxt[0];
        end
        w_pop_nxt  = (w_state_nxt == c_st_pop);
        w_busy_nxt = (w_state_nxt != c_st_idle);
        w_done_nxt = (w_state_nxt == c_st_stop) && (w_clk_cnt_nxt == c_cnt_last);
    end

    // State, counters and registered outputs; reset forces the line idle at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_st_idle;
            r_clk_cnt <= '0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            r_tx      <= 1'b1;
            r_pop     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
            r_pop     <= w_pop_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign tx        = r_tx;
    assign fifo_pop  = r_pop;
    assign busy      = r_busy;
    assign byte_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_uart_tx
//  Description : Self-checking bench for fifo_uart_tx. Two instances run side
//                by side (4 and 2 clks per bit), each fed by a small FIFO
//                model. A frame decoder compares received bytes against a
//                queue of expected bytes filled when the bytes are pushed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;

    // instance 0: CLKS_PER_BIT = 4
    logic       empty0, pop0, tx0, busy0, bd0;
    logic [7:0] fd0 = 8'd0;
    logic [7:0] mem0 [64];
    int         wp0 = 0, rp0 = 0, pops0 = 0;

    // instance 1: CLKS_PER_BIT = 2
    logic       empty1, pop1, tx1, busy1, bd1;
    logic [7:0] fd1 = 8'd0;
    logic [7:0] mem1 [64];
    int         wp1 = 0, rp1 = 0, pops1 = 0;

    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];
    int         starts0 [$];
    int         starts1 [$];
    int         bd_cnt [2];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    fifo_uart_tx #(.CLKS_PER_BIT(4), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(empty0),
        .fifo_data(fd0), .fifo_pop(pop0), .tx(tx0), .busy(busy0), .byte_done(bd0)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(2), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(empty1),
        .fifo_data(fd1), .fifo_pop(pop1), .tx(tx1), .busy(busy1), .byte_done(bd1)
    );

    always #5 clk = ~clk;

    assign empty0 = (wp0 == rp0);
    assign empty1 = (wp1 == rp1);

    // FIFO models: data appears the cycle after the pop cycle
    always @(posedge clk) begin
        if (pop0 && !empty0) begin
            fd0   <= mem0[rp0 % 64];
            rp0   <= rp0 + 1;
        end
        if (pop0) pops0 <= pops0 + 1;
        if (pop1 && !empty1) begin
            fd1   <= mem1[rp1 % 64];
            rp1   <= rp1 + 1;
        end
        if (pop1) pops1 <= pops1 + 1;
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push0(input logic [7:0] b, input bit expect_tx);
        mem0[wp0 % 64] = b;
        wp0 = wp0 + 1;
        if (expect_tx) exp_q0.push_back(b);
    endtask

    task automatic push1(input logic [7:0] b);
        mem1[wp1 % 64] = b;
        wp1 = wp1 + 1;
        exp_q1.push_back(b);
    endtask

    task automatic wait_start0(input int n);
        int k;
        k = 0;
        while (starts0.size() < n && k < 2000) begin
            @(negedge clk); #1;
            k++;
        end
        if (starts0.size() < n) check_eq("start_timeout", 0, 1);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame decoder for both instances, sampling on the falling clock edge
    initial begin : monitor
        logic       t, bd, pp, em, last;
        logic [9:0] bits [2];
        logic [7:0] e;
        int         cnt [2];
        bit         act [2];
        int         c, k, ph;
        act[0] = 0; act[1] = 0; cnt[0] = 0; cnt[1] = 0;
        bd_cnt[0] = 0; bd_cnt[1] = 0;
        bits[0] = '0; bits[1] = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                t  = (i == 0) ? tx0 : tx1;
                bd = (i == 0) ? bd0 : bd1;
                pp = (i == 0) ? pop0 : pop1;
                em = (i == 0) ? empty0 : empty1;
                c  = (i == 0) ? 4 : 2;
                if (bd) bd_cnt[i]++;
                if (pp && em) check_eq("pop_when_empty", 1, 0);
                if (!rst) begin
                    act[i] = 0;
                end else if (!act[i]) begin
                    if (bd) check_eq("byte_done_idle", bd, 0);
                    if (t == 1'b0) begin
                        act[i] = 1;
                        cnt[i] = 0;
                        bits[i] = '0;
                        if (i == 0) starts0.push_back(cyc);
                        else        starts1.push_back(cyc);
                    end
                end
                if (rst && act[i]) begin
                    k  = cnt[i] / c;
                    ph = cnt[i] % c;
                    if (ph == 0) bits[i][k] = t;
                    else if (t !== bits[i][k]) check_eq("tx_hold", t, bits[i][k]);
                    last = (cnt[i] == 10 * c - 1);
                    if (bd !== last) check_eq("byte_done_pos", bd, last);
                    if (last) begin
                        check_eq("start_bit", bits[i][0], 0);
                        check_eq("stop_bit", bits[i][9], 1);
                        if (i == 0) begin
                            if (exp_q0.size() == 0) check_eq("unexpected_frame0", 1, 0);
                            else begin e = exp_q0.pop_front(); check_eq("data0", bits[i][8:1], e); end
                        end else begin
                            if (exp_q1.size() == 0) check_eq("unexpected_frame1", 1, 0);
                            else begin e = exp_q1.pop_front(); check_eq("data1", bits[i][8:1], e); end
                        end
                        act[i] = 0;
                    end else begin
                        cnt[i]++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int p0, n, b0, pc;
        // 1: asynchronous reset with no clock edge
        #2 rst = 1'b0;
        #1;
        check_eq("rst_tx", tx0, 1);
        check_eq("rst_pop", pop0, 0);
        check_eq("rst_busy", busy0, 0);
        check_eq("rst_done", bd0, 0);
        step(3);
        rst = 1'b1;
        step(2);

        // 2: single byte 0xA5, latency from fifo_empty falling
        enable = 1'b1;
        p0 = pops0; b0 = bd_cnt[0];
        push0(8'hA5, 1);
        pc = cyc;
        wait_start0(1);
        check_eq("first_latency", starts0[0] - pc, 3);
        step(20);
        check_eq("busy_mid", busy0, 1);
        step(30);
        check_eq("single_pops", pops0 - p0, 1);
        check_eq("single_done", bd_cnt[0] - b0, 1);
        check_eq("single_idle_busy", busy0, 0);
        check_eq("single_idle_tx", tx0, 1);

        // 3: three preloaded bytes back to back
        enable = 1'b0;
        step(1);
        p0 = pops0; b0 = bd_cnt[0]; n = starts0.size();
        push0(8'h00, 1); push0(8'hFF, 1); push0(8'h55, 1);
        enable = 1'b1;
        wait_start0(n + 3);
        step(50);
        check_eq("burst_pops", pops0 - p0, 3);
        check_eq("burst_done", bd_cnt[0] - b0, 3);
        check_eq("burst_period1", starts0[n + 1] - starts0[n], 42);
        check_eq("burst_period2", starts0[n + 2] - starts0[n + 1], 42);
        check_eq("burst_busy", busy0, 0);

        // 4: enable low holds off; drop enable during data bit 3
        enable = 1'b0;
        step(1);
        p0 = pops0; n = starts0.size();
        push0(8'hE7, 1);
        push0(8'h3C, 0);
        step(200);
        check_eq("hold_pops", pops0 - p0, 0);
        check_eq("hold_busy", busy0, 0);
        enable = 1'b1;
        wait_start0(n + 1);
        step(17);
        enable = 1'b0;
        step(60);
        check_eq("drop_pops", pops0 - p0, 1);
        check_eq("drop_frames", starts0.size() - n, 1);
        check_eq("drop_busy", busy0, 0);

        // 5: reset during data bit 5; 0x3C is lost, 0x96 follows
        exp_q0.push_back(8'h3C);
        push0(8'h96, 1);
        n = starts0.size();
        enable = 1'b1;
        wait_start0(n + 1);
        repeat (25) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("midrst_tx", tx0, 1);
        check_eq("midrst_busy", busy0, 0);
        check_eq("midrst_pop", pop0, 0);
        if (exp_q0.size() > 0) void'(exp_q0.pop_front());
        step(2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("rel_pop", pop0, 1);
        wait_start0(n + 2);
        step(50);
        check_eq("rel_busy", busy0, 0);

        // 6: fifo_empty rises during the stop bit -> no further pop
        p0 = pops0; n = starts0.size();
        push0(8'h11, 1);
        push0(8'h22, 0);
        wait_start0(n + 1);
        step(37);
        wp0 = wp0 - 1;
        step(30);
        check_eq("stop_empty_pops", pops0 - p0, 1);
        check_eq("stop_empty_frames", starts0.size() - n, 1);
        check_eq("stop_empty_busy", busy0, 0);

        // 6b: two clks per bit, back to back
        p0 = pops1;
        push1(8'h5A);
        push1(8'hC3);
        step(80);
        check_eq("c2_pops", pops1 - p0, 2);
        check_eq("c2_frames", starts1.size(), 2);
        if (starts1.size() >= 2) check_eq("c2_period", starts1[1] - starts1[0], 22);
        check_eq("c2_done", bd_cnt[1], 2);

        check_eq("exp_q0_drained", exp_q0.size(), 0);
        check_eq("exp_q1_drained", exp_q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
